// File: rtl/seq_trig_hwt.sv
// Sequence-triggered payload block: a registered golden function whose output is
// corrupted for PAY_LEN valid samples after SEQ_LEN consecutive valid TRIG_PAT samples.
module seq_trig_hwt #(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] TRIG_PAT = WIDTH'(4'b1111),
   parameter int               SEQ_LEN  = 3,
   parameter int               PAY_LEN  = 4,
   parameter int               MODE     = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] x,
   input  logic             in_valid,
   input  logic             trig_en,
   output logic             y,
   output logic             out_valid,
   output logic             armed,
   output logic [7:0]       trig_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MATCH = 2'd1,
      ARMED = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] match_cnt_q, match_cnt_d;
   logic [7:0] pay_cnt_q, pay_cnt_d;
   logic [7:0] trig_cnt_q, trig_cnt_d;
   logic       y_q, y_d;
   logic       out_valid_q, out_valid_d;

   logic       g;
   logic       hit;
   logic       payload;
   logic [7:0] trig_inc;

   assign g        = x[WIDTH-1] & (x[WIDTH-2] | (&x[WIDTH-3:0]));
   assign hit      = (x == TRIG_PAT);
   assign payload  = (MODE == 0) ? ~g : 1'b0;
   assign trig_inc = (trig_cnt_q == 8'hFF) ? trig_cnt_q : trig_cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      pay_cnt_d   = pay_cnt_q;
      trig_cnt_d  = trig_cnt_q;
      y_d         = y_q;
      out_valid_d = in_valid;

      // The completing sample is still in MATCH here, so it passes through uncorrupted.
      if (in_valid) begin
         y_d = (state_q == ARMED && trig_en) ? payload : g;
      end

      if (!trig_en) begin
         state_d     = IDLE;
         match_cnt_d = 4'd0;
         pay_cnt_d   = 8'd0;
      end else if (in_valid) begin
         case (state_q)
            IDLE: begin
               if (hit) begin
                  if (SEQ_LEN == 1) begin
                     state_d     = ARMED;
                     match_cnt_d = 4'd0;
                     pay_cnt_d   = 8'(PAY_LEN);
                     trig_cnt_d  = trig_inc;
                  end else begin
                     state_d     = MATCH;
                     match_cnt_d = 4'd1;
                  end
               end
            end
            MATCH: begin
               if (hit) begin
                  if (match_cnt_q + 4'd1 == 4'(SEQ_LEN)) begin
                     state_d     = ARMED;
                     match_cnt_d = 4'd0;
                     pay_cnt_d   = 8'(PAY_LEN);
                     trig_cnt_d  = trig_inc;
                  end else begin
                     match_cnt_d = match_cnt_q + 4'd1;
                  end
               end else begin
                  // A broken run never doubles as the start of a new one.
                  state_d     = IDLE;
                  match_cnt_d = 4'd0;
               end
            end
            ARMED: begin
               pay_cnt_d = pay_cnt_q - 8'd1;
               if (pay_cnt_q == 8'd1) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d     = IDLE;
               match_cnt_d = 4'd0;
               pay_cnt_d   = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         match_cnt_q <= 4'd0;
         pay_cnt_q   <= 8'd0;
         trig_cnt_q  <= 8'd0;
         y_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         match_cnt_q <= match_cnt_d;
         pay_cnt_q   <= pay_cnt_d;
         trig_cnt_q  <= trig_cnt_d;
         y_q         <= y_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign y         = y_q;
   assign out_valid = out_valid_q;
   assign armed     = (state_q == ARMED);
   assign trig_cnt  = trig_cnt_q;

endmodule

// File: tb/tb_seq_trig_hwt.sv
// Bench for seq_trig_hwt: three configurations driven in lockstep, checked against
// a run-length / payload-budget reference model plus hand-written expectation tables.
module tb_seq_trig_hwt;

   logic       clk;
   logic       rst_n;
   logic [3:0] x4;
   logic [4:0] x5;
   logic       in_valid;
   logic       trig_en;

   logic       y_w [3];
   logic       ov_w [3];
   logic       arm_w [3];
   logic [7:0] tc_w [3];

   int n_cmp;
   int n_bad;

   // Configurations: 0 = defaults, 1 = MODE 1 / PAY_LEN 2, 2 = WIDTH 5 / SEQ_LEN 1 / PAY_LEN 1
   seq_trig_hwt dut0 (
      .clk(clk), .rst_n(rst_n), .x(x4), .in_valid(in_valid), .trig_en(trig_en),
      .y(y_w[0]), .out_valid(ov_w[0]), .armed(arm_w[0]), .trig_cnt(tc_w[0]));

   seq_trig_hwt #(.PAY_LEN(2), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .x(x4), .in_valid(in_valid), .trig_en(trig_en),
      .y(y_w[1]), .out_valid(ov_w[1]), .armed(arm_w[1]), .trig_cnt(tc_w[1]));

   seq_trig_hwt #(.WIDTH(5), .TRIG_PAT(5'b10110), .SEQ_LEN(1), .PAY_LEN(1), .MODE(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .x(x5), .in_valid(in_valid), .trig_en(trig_en),
      .y(y_w[2]), .out_valid(ov_w[2]), .armed(arm_w[2]), .trig_cnt(tc_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: length of the current matching run and remaining payload budget.
   int   m_seq  [3] = '{3, 3, 1};
   int   m_pay  [3] = '{4, 2, 1};
   int   m_mode [3] = '{0, 1, 0};
   logic [4:0] m_pat [3] = '{5'b01111, 5'b01111, 5'b10110};
   int   m_run  [3];
   int   m_left [3];
   int   m_tcnt [3];
   logic m_y    [3];
   logic m_ov   [3];

   function automatic logic golden(int k, logic [4:0] xv);
      if (k == 2) return xv[4] & (xv[3] | (xv[2] & xv[1] & xv[0]));
      return xv[3] & (xv[2] | (xv[1] & xv[0]));
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_run[k] = 0; m_left[k] = 0; m_tcnt[k] = 0; m_y[k] = 1'b0; m_ov[k] = 1'b0;
      end
   endtask

   task automatic model_step(logic v, logic [3:0] xa, logic [4:0] xb, logic en);
      logic [4:0] xv;
      logic       gv;
      for (int k = 0; k < 3; k++) begin
         xv = (k == 2) ? xb : {1'b0, xa};
         gv = golden(k, xv);
         m_ov[k] = v;
         if (!en) begin
            if (v) m_y[k] = gv;
            m_run[k] = 0;
            m_left[k] = 0;
         end else if (v) begin
            if (m_left[k] > 0) begin
               m_y[k] = (m_mode[k] == 0) ? ~gv : 1'b0;
               m_left[k]--;
            end else begin
               m_y[k] = gv;
               if (xv == m_pat[k]) begin
                  m_run[k]++;
                  if (m_run[k] == m_seq[k]) begin
                     m_run[k] = 0;
                     m_left[k] = m_pay[k];
                     if (m_tcnt[k] < 255) m_tcnt[k]++;
                  end
               end else begin
                  m_run[k] = 0;
               end
            end
         end
      end
   endtask

   task automatic chk(string name, int k, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      for (int k = 0; k < 3; k++) begin
         chk("y", k, int'(y_w[k]), int'(m_y[k]));
         chk("out_valid", k, int'(ov_w[k]), int'(m_ov[k]));
         chk("armed", k, int'(arm_w[k]), (m_left[k] > 0) ? 1 : 0);
         chk("trig_cnt", k, int'(tc_w[k]), m_tcnt[k]);
      end
   endtask

   task automatic step(logic v, logic [3:0] xa, logic [4:0] xb, logic en);
      in_valid = v; x4 = xa; x5 = xb; trig_en = en;
      model_step(v, xa, xb, en);
      @(posedge clk);
      #1;
      chk_model();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; trig_en = 1'b0; x4 = '0; x5 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic       v;
      logic [3:0] x;
      logic       en;
      logic       ey;
      logic       ea;
   } vec_t;

   vec_t       tbl [24];
   logic [15:0] g_ones;
   logic [3:0]  p1111, p1100, p0000;
   logic [4:0]  rx5;
   logic        rv, ren;
   logic [3:0]  rx4;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      p1111 = 4'b1111; p1100 = 4'b1100; p0000 = 4'b0000;

      // Golden sweep with trigger logic disabled, then the default trigger scenario.
      g_ones = 16'b1111_1000_0000_0000;
      for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 4'(i), 1'b0, g_ones[i], 1'b0};
      tbl[16] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0};
      tbl[17] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0};
      tbl[18] = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1};
      tbl[19] = '{1'b1, 4'b1100, 1'b1, 1'b0, 1'b1};
      tbl[20] = '{1'b1, 4'b1100, 1'b1, 1'b0, 1'b1};
      tbl[21] = '{1'b1, 4'b1100, 1'b1, 1'b0, 1'b1};
      tbl[22] = '{1'b1, 4'b1100, 1'b1, 1'b0, 1'b0};
      tbl[23] = '{1'b1, 4'b1100, 1'b1, 1'b1, 1'b0};

      do_reset();
      for (int k = 0; k < 3; k++) begin
         chk("rst_y", k, int'(y_w[k]), 0);
         chk("rst_out_valid", k, int'(ov_w[k]), 0);
         chk("rst_trig_cnt", k, int'(tc_w[k]), 0);
      end

      for (int i = 0; i < 24; i++) begin
         step(tbl[i].v, tbl[i].x, 5'(i), tbl[i].en);
         chk("tbl_y", 0, int'(y_w[0]), int'(tbl[i].ey));
         chk("tbl_armed", 0, int'(arm_w[0]), int'(tbl[i].ea));
         chk("tbl_out_valid", 0, int'(ov_w[0]), 1);
      end
      chk("tbl_trig_cnt", 0, int'(tc_w[0]), 1);

      // Broken sequence: no overlap restart on the sample after the break.
      do_reset();
      step(1, p1111, 5'd0, 1); step(1, p1111, 5'd0, 1);
      step(1, p0000, 5'd0, 1); step(1, p1111, 5'd0, 1);
      step(1, p0000, 5'd0, 1);
      chk("broken_armed", 0, int'(arm_w[0]), 0);
      chk("broken_trig_cnt", 0, int'(tc_w[0]), 0);

      // Invalid gaps inside the run neither break nor advance it.
      step(1, p1111, 5'd0, 1); step(0, p0000, 5'd0, 1);
      step(1, p1111, 5'd0, 1); step(0, p0000, 5'd0, 1); step(0, p1100, 5'd0, 1);
      step(1, p1111, 5'd0, 1);
      chk("gap_armed", 0, int'(arm_w[0]), 1);
      chk("gap_trig_cnt", 0, int'(tc_w[0]), 1);
      chk("gap_out_valid_low", 0, 0, 0 & int'(ov_w[0]));

      // MODE 1 / PAY_LEN 2 instance: forced zero twice, then golden again.
      step(1, p1100, 5'd0, 1);
      chk("mode1_pay1", 1, int'(y_w[1]), 0);
      step(1, p1100, 5'd0, 1);
      chk("mode1_pay2", 1, int'(y_w[1]), 0);
      step(1, p1100, 5'd0, 1);
      chk("mode1_after", 1, int'(y_w[1]), 1);
      chk("mode1_armed", 1, int'(arm_w[1]), 0);

      // Mid-payload abort via trig_en.
      do_reset();
      step(1, p1111, 5'd0, 1); step(1, p1111, 5'd0, 1); step(1, p1111, 5'd0, 1);
      step(1, p1100, 5'd0, 1);
      step(0, p0000, 5'd0, 0);
      chk("abort_armed", 0, int'(arm_w[0]), 0);
      step(1, p1100, 5'd0, 1);
      chk("abort_y", 0, int'(y_w[0]), 1);

      // Asynchronous reset at the second payload sample.
      do_reset();
      step(1, p1111, 5'd0, 1); step(1, p1111, 5'd0, 1); step(1, p1111, 5'd0, 1);
      step(1, p1100, 5'd0, 1);
      in_valid = 1'b1; x4 = p1100; trig_en = 1'b1;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("async_y", k, int'(y_w[k]), 0);
         chk("async_out_valid", k, int'(ov_w[k]), 0);
         chk("async_armed", k, int'(arm_w[k]), 0);
         chk("async_trig_cnt", k, int'(tc_w[k]), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, p1100, 5'd0, 1);
      chk("post_rst_y", 0, int'(y_w[0]), 1);
      chk("post_rst_armed", 0, int'(arm_w[0]), 0);
      step(1, p1111, 5'd0, 1); step(1, p1111, 5'd0, 1);
      chk("post_rst_no_trig", 0, int'(arm_w[0]), 0);

      // Randomised traffic; trig_en drops only on idle-input cycles.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         ren = ($urandom_range(0, 15) != 0);
         rv  = ren ? ($urandom_range(0, 3) != 0) : 1'b0;
         rx4 = ($urandom_range(0, 1) == 0) ? p1111 : 4'($urandom_range(0, 15));
         rx5 = ($urandom_range(0, 2) == 0) ? 5'b10110 : 5'($urandom_range(0, 31));
         step(rv, rx4, rx5, ren);
      end

      // Saturation: 260 trigger events on the default instance.
      do_reset();
      for (int e = 0; e < 260; e++) begin
         for (int i = 0; i < 3; i++) step(1, p1111, 5'($urandom_range(0, 31)), 1);
         for (int i = 0; i < 4; i++) step(1, p1100, 5'($urandom_range(0, 31)), 1);
      end
      chk("sat_trig_cnt", 0, int'(tc_w[0]), 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_trig_hwt.md
SEQ_TRIG_HWT -- requirements
Module: seq_trig_hwt

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 4: width of data input x; legal values 3..16.
REQ-002 The block SHALL have the parameter TRIG_PAT, default 4'b1111 (WIDTH bits): trigger pattern value.
REQ-003 The block SHALL have the parameter SEQ_LEN, default 3: consecutive matching valid samples needed to trigger; legal values 1..15.
REQ-004 The block SHALL have the parameter PAY_LEN, default 4: valid samples corrupted per trigger event; legal values 1..255.
REQ-005 The block SHALL have the parameter MODE, default 0: payload type; 0 = invert y, 1 = force y to 0.
REQ-006 The block SHALL have the port clk, input, 1 bit: single clock, rising edge.
REQ-007 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have the port x, input, WIDTH bits: data sample; x[WIDTH-1] is MSB.
REQ-009 The block SHALL have the port in_valid, input, 1 bit: x is valid this cycle.
REQ-010 The block SHALL have the port trig_en, input, 1 bit: 0 holds the trigger logic in IDLE, giving a golden-only circuit.
REQ-011 The block SHALL have the port y, output, 1 bit: registered function result.
REQ-012 The block SHALL have the port out_valid, output, 1 bit: y is valid this cycle.
REQ-013 The block SHALL have the port armed, output, 1 bit: the payload is active for the next valid sample.
REQ-014 The block SHALL have the port trig_cnt, output, 8 bits: saturating count of trigger events.

Function
REQ-015 The golden function SHALL be g = x[WIDTH-1] & (x[WIDTH-2] | &x[WIDTH-3:0]); for WIDTH=4 this is x[3] & (x[2] | (x[1] & x[0])).
REQ-016 y and out_valid SHALL be registered with 1-cycle latency: a sample with in_valid=1 at edge N appears at y with out_valid=1 after edge N.
REQ-017 out_valid SHALL be 0 in any cycle following an in_valid=0 cycle.
REQ-018 y SHALL hold its previous value when out_valid=0.
REQ-019 The FSM SHALL have the states IDLE, MATCH and ARMED, with a match counter (4 bits) and a payload counter (8 bits).
REQ-020 In IDLE, a valid sample with x==TRIG_PAT and trig_en=1 SHALL set the match counter to 1, then go to MATCH, or go directly to ARMED if SEQ_LEN=1.
REQ-021 In MATCH, a valid matching sample SHALL increment the match counter; on reaching SEQ_LEN the FSM SHALL go to ARMED, load the payload counter with PAY_LEN and increment trig_cnt.
REQ-022 In MATCH, a valid non-matching sample SHALL clear the match counter and return the FSM to IDLE, even if that sample equals the start of a new sequence; no overlap restart.
REQ-023 Cycles with in_valid=0 SHALL leave the FSM and the counters unchanged in every state.
REQ-024 The sample that completes the match SHALL be output uncorrupted; the payload starts with the next valid sample.
REQ-025 In ARMED, each valid sample SHALL be output as the payload value: ~g for MODE 0, 0 for MODE 1; the payload counter SHALL then decrement.
REQ-026 When the payload counter reaches 0 after a decrement, the FSM SHALL return to IDLE; matching samples seen during ARMED SHALL be ignored for triggering.
REQ-027 armed SHALL be 1 exactly while the FSM is in ARMED.
REQ-028 trig_en=0 SHALL force the FSM to IDLE and clear both counters on the next edge, including a mid-ARMED abort; y SHALL then follow g from the next sample onward.
REQ-029 trig_cnt SHALL saturate at 255 and SHALL NOT wrap.
REQ-030 All registers SHALL update only on the rising edge of clk, except on asynchronous reset.

Reset
REQ-031 rst_n=0 SHALL immediately force y=0, out_valid=0, armed=0, trig_cnt=0, FSM=IDLE and both counters to 0, independent of clk.
REQ-032 Reset asserted mid-MATCH or mid-ARMED SHALL discard all progress; after release the FSM SHALL need a full new SEQ_LEN sequence to trigger.
REQ-033 The first valid sample after reset release SHALL be processed normally.

Verification
REQ-034 Golden sweep: WIDTH=4, trig_en=0, all 16 x values -> y matches g (x=4'b1011 -> 1, x=4'b1010 -> 0) and out_valid is 1 one cycle later.
REQ-035 Trigger: defaults, trig_en=1, three valid 4'b1111 samples, then 4'b1100 x5 -> the 3rd sample outputs y=1, armed=1; the next four outputs are y=0 (inverted g=1), the fifth outputs y=1; trig_cnt=1.
REQ-036 Broken sequence: 1111, 1111, 0000, 1111 -> no trigger, armed stays 0, trig_cnt=0; gaps with in_valid=0 inside 1111 x3 still trigger.
REQ-037 MODE=1, PAY_LEN=2: trigger, then x=4'b1100 twice -> y=0 both; third -> y=1.
REQ-038 Reset at 2nd payload sample -> outputs cleared asynchronously; post-release 4'b1100 -> y=1, armed=0.
REQ-039 Saturation: 260 trigger events -> trig_cnt=255.
